// File: rtl/seq_pkg.sv
// Shared types and helpers for the move queue sequencer: FSM state
// enums, the NOP move code and the load word width helper.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    ACK_GAP   = 3'd2,
    WAIT_DONE = 3'd3,
    STARVE    = 3'd4,
    FINISH    = 3'd5
  } disp_state_t;

  typedef enum logic {
    U_IDLE  = 1'b0,
    U_SHIFT = 1'b1
  } unpack_state_t;

  localparam int NOP_CODE = 0;

  function automatic int load_word_w(input int move_w, input int moves_per_word);
    return move_w * moves_per_word;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Circular move buffer with push/pop/flush, occupancy count and
// full/empty flags. DEPTH must be a power of two so pointers wrap naturally.
module move_fifo #(
  parameter int DEPTH  = 256,
  parameter int MOVE_W = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [MOVE_W-1:0] push_data,
  input  logic              pop,
  output logic [MOVE_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [MOVE_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign push_ok_s = push && !full && !flush;
  assign pop_ok_s  = pop && !empty && !flush;

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == '0);

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/move_queue_sequencer.sv
// Unpacks packed move words into a FIFO and dispatches them with a
// start/done handshake. Optional watchdog: define SEQ_TIMEOUT_EN.
module move_queue_sequencer import seq_pkg::*; #(
  parameter int MOVE_W         = 4,
  parameter int MOVES_PER_WORD = 50,
  parameter int DEPTH          = 256,
  parameter int CNT_W          = $clog2(DEPTH) + 1,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [MOVE_W*MOVES_PER_WORD-1:0] load_word,
  input  logic                             run,
  input  logic                             abort,
  output logic                             start_move,
  output logic [MOVE_W-1:0]                next_move,
  input  logic                             move_done,
  output logic                             seq_done,
  output logic [CNT_W-1:0]                 queue_count,
  output logic [CNT_W-1:0]                 curr_step,
  output logic                             busy,
  output logic                             move_timeout
);

  localparam int WORD_W = load_word_w(MOVE_W, MOVES_PER_WORD);
  localparam int SLOT_W = $clog2(MOVES_PER_WORD + 1);

  unpack_state_t     u_state_r, u_next_s;
  logic [WORD_W-1:0] word_r, word_next_s, word_shift_s;
  logic [SLOT_W-1:0] slot_cnt_r, slot_next_s;
  logic [MOVE_W-1:0] slot_s;
  logic              push_s;

  disp_state_t       d_state_r, d_next_s;
  logic              start_move_r, start_next_s;
  logic [MOVE_W-1:0] next_move_r, next_move_next_s;
  logic              seq_done_r, seq_done_next_s;
  logic [CNT_W-1:0]  curr_step_r, step_next_s;
  logic              pop_s;

  logic [MOVE_W-1:0] fifo_head_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              timeout_fire_s;
  logic              abort_s;

  assign abort_s      = abort || timeout_fire_s;
  assign slot_s       = word_r[WORD_W-1 -: MOVE_W];
  assign word_shift_s = word_r << MOVE_W;

  move_fifo #(.DEPTH(DEPTH), .MOVE_W(MOVE_W), .CNT_W(CNT_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (abort_s),
    .push      (push_s),
    .push_data (slot_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Unpacker next state: examine the MSB slot, hold on a full FIFO.
  always_comb begin
    u_next_s    = u_state_r;
    word_next_s = word_r;
    slot_next_s = slot_cnt_r;
    push_s      = 1'b0;
    if (abort_s) begin
      u_next_s = U_IDLE;
    end else begin
      case (u_state_r)
        U_IDLE: begin
          if (load_valid) begin
            u_next_s    = U_SHIFT;
            word_next_s = load_word;
            slot_next_s = '0;
          end else begin
            u_next_s = U_IDLE;
          end
        end
        U_SHIFT: begin
          if ((slot_s != MOVE_W'(NOP_CODE)) && fifo_full_s) begin
            u_next_s = U_SHIFT;
          end else begin
            push_s      = (slot_s != MOVE_W'(NOP_CODE));
            word_next_s = word_shift_s;
            slot_next_s = slot_cnt_r + SLOT_W'(1);
            if ((word_shift_s == '0) || (slot_cnt_r == SLOT_W'(MOVES_PER_WORD - 1))) begin
              u_next_s = U_IDLE;
            end else begin
              u_next_s = U_SHIFT;
            end
          end
        end
        default: u_next_s = U_IDLE;
      endcase
    end
  end

  // Unpacker state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      u_state_r  <= U_IDLE;
      word_r     <= '0;
      slot_cnt_r <= '0;
    end else begin
      u_state_r  <= u_next_s;
      word_r     <= word_next_s;
      slot_cnt_r <= slot_next_s;
    end
  end

  // Dispatch next state and registered-output values.
  always_comb begin
    d_next_s         = d_state_r;
    pop_s            = 1'b0;
    start_next_s     = 1'b0;
    next_move_next_s = next_move_r;
    seq_done_next_s  = 1'b0;
    step_next_s      = curr_step_r;
    if (abort_s) begin
      d_next_s         = IDLE;
      next_move_next_s = '0;
    end else begin
      case (d_state_r)
        IDLE: begin
          if (run && !fifo_empty_s) begin
            d_next_s    = ISSUE;
            step_next_s = '0;
          end else begin
            d_next_s = IDLE;
          end
        end
        ISSUE: begin
          pop_s            = 1'b1;
          start_next_s     = 1'b1;
          next_move_next_s = fifo_head_s;
          step_next_s      = (curr_step_r == '1) ? curr_step_r : curr_step_r + CNT_W'(1);
          d_next_s         = ACK_GAP;
        end
        ACK_GAP: d_next_s = WAIT_DONE;
        WAIT_DONE: begin
          if (!move_done)               d_next_s = WAIT_DONE;
          else if (!fifo_empty_s)       d_next_s = ISSUE;
          else if (u_state_r == U_SHIFT) d_next_s = STARVE;
          else                          d_next_s = FINISH;
        end
        STARVE: begin
          if (!fifo_empty_s)            d_next_s = ISSUE;
          else if (u_state_r == U_IDLE) d_next_s = FINISH;
          else                          d_next_s = STARVE;
        end
        FINISH: begin
          seq_done_next_s  = 1'b1;
          next_move_next_s = '0;
          d_next_s         = IDLE;
        end
        default: d_next_s = IDLE;
      endcase
    end
  end

  // Dispatch state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_state_r    <= IDLE;
      start_move_r <= 1'b0;
      next_move_r  <= '0;
      seq_done_r   <= 1'b0;
      curr_step_r  <= '0;
    end else begin
      d_state_r    <= d_next_s;
      start_move_r <= start_next_s;
      next_move_r  <= next_move_next_s;
      seq_done_r   <= seq_done_next_s;
      curr_step_r  <= step_next_s;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wd_cnt_r;
  logic            move_timeout_r;

  // Fires on the TIMEOUT_CYCLES-th consecutive WAIT_DONE cycle without move_done.
  assign timeout_fire_s = (d_state_r == WAIT_DONE) && !move_done && !abort &&
                          (wd_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
  assign move_timeout   = move_timeout_r;

  // Watchdog counter and sticky timeout flag, cleared by the next run.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_r       <= '0;
      move_timeout_r <= 1'b0;
    end else begin
      if ((d_state_r == WAIT_DONE) && !abort_s) wd_cnt_r <= wd_cnt_r + TO_W'(1);
      else                                      wd_cnt_r <= '0;
      if (timeout_fire_s) move_timeout_r <= 1'b1;
      else if (run)       move_timeout_r <= 1'b0;
      else                move_timeout_r <= move_timeout_r;
    end
  end
`else
  logic timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT_CYCLES != 0);
  assign timeout_fire_s   = 1'b0;
  assign move_timeout     = 1'b0;
`endif

  assign load_ready  = (u_state_r == U_IDLE);
  assign start_move  = start_move_r;
  assign next_move   = next_move_r;
  assign seq_done    = seq_done_r;
  assign queue_count = fifo_count_s;
  assign curr_step   = curr_step_r;
  assign busy        = (d_state_r != IDLE);

endmodule

// File: tb/tb_move_queue_sequencer.sv
// Directed bench for move_queue_sequencer (MOVE_W=4, 8 slots/word, DEPTH=4,
// TIMEOUT_CYCLES=100); the watchdog scenario follows SEQ_TIMEOUT_EN.
module tb_move_queue_sequencer;

  localparam int MW = 4;
  localparam int MPW = 8;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [31:0]   load_word = 32'h0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic          start_move;
  logic [MW-1:0] next_move;
  logic          move_done = 1'b0;
  logic          seq_done;
  logic [CW-1:0] queue_count;
  logic [CW-1:0] curr_step;
  logic          busy;
  logic          move_timeout;

  int total = 0;
  int bad = 0;
  int rec_moves[$];
  int rec_start_c[$];
  int rec_done_c[$];
  int seq_cnt;
  int seq_c;

  move_queue_sequencer #(.MOVE_W(MW), .MOVES_PER_WORD(MPW), .DEPTH(DP), .CNT_W(CW),
                         .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_word(load_word), .run(run), .abort(abort), .start_move(start_move),
    .next_move(next_move), .move_done(move_done), .seq_done(seq_done),
    .queue_count(queue_count), .curr_step(curr_step), .busy(busy),
    .move_timeout(move_timeout)
  );

  always #5 clock = ~clock;

  task automatic load(input logic [31:0] w, input bit wait_idle, output bit ok);
    @(negedge clock); load_valid = 1'b1; load_word = w;
    @(negedge clock); load_valid = 1'b0;
    ok = 1'b1;
    if (wait_idle) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (load_ready) begin ok = 1'b1; break; end
        @(negedge clock);
      end
    end
  endtask

  task automatic pulse_run();
    @(negedge clock); run = 1'b1;
    @(negedge clock); run = 1'b0;
  endtask

  // Fixed-length window: records issued moves, acks 5 cycles after each start.
  task automatic collect(input int cycles, input logic [31:0] extra_word, input bit use_extra);
    int ack_at;
    bit pend;
    ack_at = -1; pend = use_extra;
    rec_moves.delete(); rec_start_c.delete(); rec_done_c.delete();
    seq_cnt = 0; seq_c = -1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      move_done = 1'b0; load_valid = 1'b0;
      if (seq_done) begin seq_cnt++; if (seq_c < 0) seq_c = c; end
      if (start_move) begin
        rec_moves.push_back(int'(next_move)); rec_start_c.push_back(c); ack_at = c + 5;
      end
      if (c == ack_at) begin move_done = 1'b1; rec_done_c.push_back(c); end
      if (pend && load_ready) begin load_valid = 1'b1; load_word = extra_word; pend = 1'b0; end
    end
    @(negedge clock); move_done = 1'b0; load_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL rst_load_ready got=%0b want=1", load_ready); end
    total++; if ({start_move, seq_done, busy, move_timeout} !== 4'b0000) begin bad++;
      $display("FAIL rst_flags got=%b want=0000", {start_move, seq_done, busy, move_timeout}); end
    total++; if ({next_move, queue_count, curr_step} !== 10'd0) begin bad++;
      $display("FAIL rst_values got=%0d/%0d/%0d want=0/0/0", next_move, queue_count, curr_step); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    int exp_m[3] = '{3, 7, 1};
    load(32'h37100000, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_load_idle got=0 want=1"); end
    total++; if (queue_count !== 3'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", queue_count); end
    pulse_run();
    collect(40, 32'h0, 1'b0);
    total++; if (rec_moves.size() != 3) begin bad++; $display("FAIL basic_nmoves got=%0d want=3", rec_moves.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (rec_moves[i] != exp_m[i]) begin bad++; $display("FAIL basic_move%0d got=%0d want=%0d", i, rec_moves[i], exp_m[i]); end
      end
      total++; if (rec_start_c[0] != 0) begin bad++; $display("FAIL run_latency got=%0d want=0", rec_start_c[0]); end
      total++; if (rec_start_c[1] - rec_done_c[0] != 2) begin bad++;
        $display("FAIL done_latency got=%0d want=2", rec_start_c[1] - rec_done_c[0]); end
      total++; if (seq_c != rec_done_c[2] + 2) begin bad++; $display("FAIL basic_seq_time got=%0d want=%0d", seq_c, rec_done_c[2] + 2); end
    end
    total++; if (seq_cnt != 1) begin bad++; $display("FAIL basic_seq_cnt got=%0d want=1", seq_cnt); end
    total++; if (curr_step !== 3'd3) begin bad++; $display("FAIL basic_step got=%0d want=3", curr_step); end
    total++; if ({busy, next_move} !== 5'd0) begin bad++; $display("FAIL basic_idle got=%0d/%0d want=0/0", busy, next_move); end
  endtask

  task automatic test_embedded_zero();
    bit ok;
    load(32'h20500000, 1'b1, ok);
    total++; if (queue_count !== 3'd2) begin bad++; $display("FAIL zero_count got=%0d want=2", queue_count); end
    pulse_run();
    collect(30, 32'h0, 1'b0);
    total++; if (rec_moves.size() != 2) begin bad++; $display("FAIL zero_nmoves got=%0d want=2", rec_moves.size()); end
    else begin
      total++; if (rec_moves[0] != 2 || rec_moves[1] != 5) begin bad++;
        $display("FAIL zero_seq got=%0d,%0d want=2,5", rec_moves[0], rec_moves[1]); end
    end
    total++; if (curr_step !== 3'd2) begin bad++; $display("FAIL zero_step got=%0d want=2", curr_step); end
  endtask

  task automatic test_full_hold();
    bit ok;
    load(32'h12345600, 1'b0, ok);
    repeat (6) @(negedge clock);
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL hold_ready got=%0b want=0", load_ready); end
    total++; if (queue_count !== 3'd4) begin bad++; $display("FAIL hold_count got=%0d want=4", queue_count); end
    pulse_run();
    collect(100, 32'h0, 1'b0);
    total++; if (rec_moves.size() != 6) begin bad++; $display("FAIL hold_nmoves got=%0d want=6", rec_moves.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        total++; if (rec_moves[i] != i + 1) begin bad++; $display("FAIL hold_move%0d got=%0d want=%0d", i, rec_moves[i], i + 1); end
      end
    end
    total++; if (seq_cnt != 1) begin bad++; $display("FAIL hold_seq_cnt got=%0d want=1", seq_cnt); end
    total++; if (curr_step !== 3'd6 || load_ready !== 1'b1) begin bad++;
      $display("FAIL hold_end got=%0d/%0b want=6/1", curr_step, load_ready); end
  endtask

  task automatic test_saturate();
    bit ok;
    load(32'h12345678, 1'b0, ok);
    repeat (6) @(negedge clock);
    pulse_run();
    collect(100, 32'h0, 1'b0);
    total++; if (rec_moves.size() != 8) begin bad++; $display("FAIL sat_nmoves got=%0d want=8", rec_moves.size()); end
    else begin
      total++; if (rec_moves[7] != 8) begin bad++; $display("FAIL sat_last got=%0d want=8", rec_moves[7]); end
    end
    total++; if (curr_step !== 3'd7) begin bad++; $display("FAIL sat_step got=%0d want=7", curr_step); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    load(32'h90000000, 1'b1, ok);
    pulse_run();
    collect(60, 32'hAB000000, 1'b1);
    total++; if (rec_moves.size() != 3) begin bad++; $display("FAIL b2b_nmoves got=%0d want=3", rec_moves.size()); end
    else begin
      total++; if (rec_moves[0] != 9 || rec_moves[1] != 10 || rec_moves[2] != 11) begin bad++;
        $display("FAIL b2b_seq got=%0d,%0d,%0d want=9,10,11", rec_moves[0], rec_moves[1], rec_moves[2]); end
      total++; if (seq_c != rec_done_c[2] + 2) begin bad++; $display("FAIL b2b_seq_time got=%0d want=%0d", seq_c, rec_done_c[2] + 2); end
    end
    total++; if (seq_cnt != 1) begin bad++; $display("FAIL b2b_seq_cnt got=%0d want=1", seq_cnt); end
  endtask

  task automatic test_abort();
    bit ok;
    int spurious;
    load(32'h12340000, 1'b1, ok);
    pulse_run();
    @(negedge clock);
    total++; if (start_move !== 1'b1) begin bad++; $display("FAIL abort_start got=%0b want=1", start_move); end
    @(negedge clock);
    total++; if (queue_count !== 3'd3 || busy !== 1'b1) begin bad++;
      $display("FAIL abort_pre got=%0d/%0b want=3/1", queue_count, busy); end
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    total++; if (queue_count !== 3'd0 || busy !== 1'b0 || start_move !== 1'b0) begin bad++;
      $display("FAIL abort_post got=%0d/%0b/%0b want=0/0/0", queue_count, busy, start_move); end
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (seq_done || start_move) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL abort_quiet got=%0d want=0", spurious); end
    // Abort together with run and load.
    load(32'h50000000, 1'b1, ok);
    @(negedge clock); run = 1'b1; abort = 1'b1; load_valid = 1'b1; load_word = 32'h60000000;
    @(negedge clock); run = 1'b0; abort = 1'b0; load_valid = 1'b0;
    total++; if (busy !== 1'b0 || queue_count !== 3'd0 || load_ready !== 1'b1) begin bad++;
      $display("FAIL abort_prio got=%0b/%0d/%0b want=0/0/1", busy, queue_count, load_ready); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int sd;
    load(32'h12000000, 1'b1, ok);
    pulse_run();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    total++; if ({busy, queue_count, curr_step, next_move} !== 11'd0 || load_ready !== 1'b1) begin bad++;
      $display("FAIL rstmid got=%0b/%0d/%0d/%0d/%0b want=0/0/0/0/1", busy, queue_count, curr_step, next_move, load_ready); end
    sd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (seq_done) sd++;
    end
    total++; if (sd != 0) begin bad++; $display("FAIL rstmid_seq got=%0d want=0", sd); end
  endtask

  task automatic test_timeout();
    bit ok;
    load(32'h12000000, 1'b1, ok);
    pulse_run();
`ifdef SEQ_TIMEOUT_EN
    for (int c = 0; c < 102; c++) begin
      @(negedge clock);
      if (c == 100) begin
        total++; if (move_timeout !== 1'b0 || busy !== 1'b1) begin bad++;
          $display("FAIL to_early got=%0b/%0b want=0/1", move_timeout, busy); end
      end
      if (c == 101) begin
        total++; if (move_timeout !== 1'b1 || busy !== 1'b0 || queue_count !== 3'd0) begin bad++;
          $display("FAIL to_fire got=%0b/%0b/%0d want=1/0/0", move_timeout, busy, queue_count); end
      end
    end
    pulse_run();
    total++; if (move_timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%0b want=0", move_timeout); end
`else
    repeat (150) @(negedge clock);
    total++; if (move_timeout !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL to_off got=%0b/%0b want=0/1", move_timeout, busy); end
    @(negedge clock); abort = 1'b1;
    @(negedge clock); abort = 1'b0;
`endif
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%0b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_embedded_zero();
    test_full_hold();
    test_saturate();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_queue_sequencer.md
Name: move_queue_sequencer

Overview:
Parametrised successor to the single-shot move sequencer. It unpacks packed move words into a circular move FIFO and dispatches moves one at a time to the motor/move controller, using a start/done handshake. Loading and execution run concurrently, so the solver can append moves while earlier moves are still executing. Sits between the solver output and the move executor.

Parameters:
MOVE_W, 4, bits per move code; code 0 is NOP and is never queued
MOVES_PER_WORD, 50, move slots per load word (load word width = MOVE_W*MOVES_PER_WORD)
DEPTH, 256, FIFO entries; must be a power of two
CNT_W, $clog2(DEPTH)+1, width of count/step outputs
TIMEOUT_CYCLES, 50000000, watchdog limit; used only with SEQ_TIMEOUT_EN

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
load_valid  in  1  load_word is valid
load_ready  out  1  high when the unpacker is idle; a word is accepted when load_valid && load_ready
load_word  in  MOVE_W*MOVES_PER_WORD  packed moves, first move in the MSB slot
run  in  1  pulse that starts dispatch of queued moves
abort  in  1  pulse that flushes the queue and stops dispatch
start_move  out  1  one-cycle pulse; next_move is valid in the same cycle
next_move  out  MOVE_W  move code being issued
move_done  in  1  executor completion pulse
seq_done  out  1  one-cycle pulse when the queue drains normally
queue_count  out  CNT_W  number of entries currently held in the FIFO
curr_step  out  CNT_W  moves issued since the last run
busy  out  1  dispatch FSM is not in IDLE
move_timeout  out  1  watchdog fired (SEQ_TIMEOUT_EN only; otherwise tied to 0)

Behaviour:
- Reset: every output is 0 except load_ready=1; FIFO pointers and count are 0; both FSMs go to IDLE. Reset mid-operation discards all queued moves and does not pulse seq_done.
- Unpacker FSM (U_IDLE, U_SHIFT):
  - On accept: capture the word and go to U_SHIFT. Each cycle, examine the MSB slot, then shift left by MOVE_W.
  - A nonzero slot is pushed to the FIFO. If the FIFO is full, the unpacker holds: no shift, no push.
  - Return to U_IDLE once the remaining bits are all zero, or after MOVES_PER_WORD slots have been examined.
  - Zero slots are skipped; they do not terminate the word early unless every remaining slot is also zero.
- FIFO: a push and a pop in the same cycle are both legal and leave the count unchanged. Popping while empty is impossible by construction. A push while full is blocked by the unpacker hold.
- Dispatch FSM (IDLE, ISSUE, ACK_GAP, WAIT_DONE, STARVE, FINISH):
  - IDLE: on run with queue_count>0, clear curr_step and go to ISSUE. A run with the queue empty is ignored.
  - ISSUE: pop; drive next_move=head and start_move=1; curr_step+1; go to ACK_GAP.
  - ACK_GAP: one dead cycle; move_done is ignored here.
  - WAIT_DONE: on move_done, go to ISSUE if count>0. If count==0 and the unpacker is busy, go to STARVE. Otherwise go to FINISH.
  - STARVE: go to ISSUE as soon as count>0; go to FINISH if the unpacker returns idle with the queue still empty.
  - FINISH: seq_done=1 for one cycle, next_move cleared to 0, go to IDLE. curr_step holds its value until the next run.
- Latency: run to start_move is 2 cycles. move_done to the next start_move is 2 cycles when the queue is non-empty.
- abort (any state): flush the FIFO, return the unpacker to U_IDLE, return the dispatch FSM to IDLE, and drop start_move. seq_done is not pulsed. abort takes priority over a simultaneous run or load.
- curr_step saturates at 2^CNT_W-1.

Optional Feature:
SEQ_TIMEOUT_EN:
- Defined: a counter runs while the dispatch FSM is in WAIT_DONE. When it reaches TIMEOUT_CYCLES, move_timeout is set sticky and an internal abort is performed. move_timeout is cleared by reset or by the next run.
- Undefined: no counter is built, move_timeout is constant 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package seq_pkg holds: the dispatch and unpacker state enums, the NOP code constant (0), and a localparam helper for the load word width.
- Sub-module move_fifo, the natural split: a circular buffer with push/pop/flush, a count output, and full/empty flags, parametrised by DEPTH and MOVE_W.

Test Plan:
- Load word with moves 3,7,1 then zeros; pulse run; ack each move 5 cycles after its start_move -> next_move sequence 3,7,1; seq_done pulses once after the third move_done; curr_step=3.
- Load word with moves 2,0,5 (embedded zero) -> queue_count=2; dispatched sequence is 2,5.
- DEPTH=4; load a word of 6 nonzero moves; run -> load_ready stays low until dispatch frees slots; all 6 moves issued in order; no move lost.
- Start a run with 1 move queued; load a second word before move_done -> FSM passes through STARVE or ISSUE, no early seq_done, all moves issued.
- abort during WAIT_DONE with 3 moves queued -> queue_count=0 and busy=0 on the next cycle; seq_done never pulses.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=100; withhold move_done -> move_timeout=1 at cycle 100 of WAIT_DONE; queue flushed; the next run clears move_timeout.
